lcd_seq_ctrl: RTL and testbench
===============================

LCD_SEQ_CTRL -- requirements
Module: lcd_seq_ctrl

Interface
REQ-001 Parameter BUS4, default 0: 0 = 8-bit LCD bus, 1 = 4-bit bus using lcd_data[7:4].
REQ-002 Parameter TWO_LINE, default 1: sets the N bit of function set.
REQ-003 Parameter CURSOR_ON, default 1; parameter BLINK_ON, default 0: set the C and B bits of display-on.
REQ-004 Parameter PWR_WAIT, default 4000: power-on wait terminal count, in clk_1024 cycles.
REQ-005 Parameter CMD_WAIT, default 3: E-low hold cycles after a normal byte.
REQ-006 Parameter CLR_WAIT, default 152: E-low hold cycles after 0x01 (clear) or 0x02 (home) commands.
REQ-007 Parameter constraint: PWR_WAIT, CMD_WAIT, CLR_WAIT each in 1..65535; all counters are 16 bit.
REQ-008 clk_1024  in  1  system clock, 1024 Hz tick domain.
REQ-009 reset_n  in  1  reset, asynchronous, active-low.
REQ-010 reinit  in  1  synchronous restart of the full init sequence.
REQ-011 wr_req  in  1  write request, valid only while ready=1.
REQ-012 wr_rs  in  1  0 = command, 1 = data register.
REQ-013 wr_data  in  8  byte to write.
REQ-014 ready  out  1  user write accepted this cycle if wr_req=1.
REQ-015 init_done  out  1  init sequence complete.
REQ-016 lcd_rw  out  1  always 0 (write-only).
REQ-017 lcd_rs  out  1  LCD register select.
REQ-018 lcd_e  out  1  LCD enable strobe.
REQ-019 lcd_data  out  8  LCD data bus.

Function
REQ-020 States: PWR, INIT_SEND, INIT_HOLD, IDLE, WR_SEND, WR_HOLD; HI/LO nibble phase flag in 4-bit mode.
REQ-021 PWR: count 0..PWR_WAIT, then INIT_SEND; PWR lasts PWR_WAIT+1 cycles.
REQ-022 Init ROM, in order: [BUS4 only: nibble 0x2 sent alone], function set 0x20|(!BUS4<<4)|(TWO_LINE<<3), display-on 0x08|0x04|(CURSOR_ON<<1)|BLINK_ON, clear 0x01, entry mode 0x06; all with rs=0.
REQ-023 Each strobe: exactly 1 cycle lcd_e=1 with rs/data valid, then lcd_e=0 with rs/data held unchanged for hold cycles.
REQ-024 8-bit byte: 1 E-high cycle + W hold cycles; W=CLR_WAIT for rs=0 bytes 0x01/0x02, else CMD_WAIT.
REQ-025 4-bit byte: high nibble on lcd_data[7:4] (1 E-high + 1 hold), then low nibble (1 E-high + W hold); lcd_data[3:0]=0 always in 4-bit mode.
REQ-026 After the last init hold cycle, next edge: init_done=1, ready=1, state IDLE.
REQ-027 IDLE: wr_req=1 at an edge -> next cycle ready=0, lcd_e=1, lcd_rs=wr_rs, byte latched; ready returns 1 the cycle after the final hold cycle.
REQ-028 wr_req while ready=0 ignored; no queuing; wr_data/wr_rs sampled only at acceptance.
REQ-029 reinit=1 at any edge, any state: next cycle lcd_e=0, init_done=0, ready=0, counters cleared, state PWR; reinit beats a simultaneous wr_req.
REQ-030 Counter terminal compare is ==; no wrap-around is reachable.
REQ-031 ready=1 only in IDLE; init_done stays 1 until reset or reinit.

Reset
REQ-032 reset_n=0: state PWR, count 0, init_done=0, ready=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
REQ-033 reset_n asserted mid-strobe forces lcd_e=0 immediately (asynchronous); release restarts from PWR.

Verification
REQ-034 Defaults, BUS4=0: release reset -> first lcd_e=1 at edge 4001 with data 0x38; then 0x0E, 0x01, 0x06 at edges 4005, 4009, 4162; init_done=1 at edge 4166.
REQ-035 BUS4=1: init strobes show nibbles 2, 2, 8, 0, E, 0, 1, 0, 6 on lcd_data[7:4]; lcd_data[3:0]=0 throughout.
REQ-036 IDLE, wr_req with rs=1, data 0x41 -> one strobe, 0x41, rs=1; ready low for 4 cycles; wr_req during busy causes no extra strobe.
REQ-037 IDLE, wr_req with rs=0, data 0x01 -> hold of 152 cycles; ready low for 153 cycles.
REQ-038 reinit pulse during the clear hold -> lcd_e=0, init_done=0; full sequence repeats with identical timing to REQ-034.

Source files
------------

// File: rtl/lcd_seq_ctrl.sv
// HD44780-style LCD sequencer: power-on wait, init command ROM, then single-byte user writes.
// Each byte is a one-cycle E strobe followed by an E-low hold; 4-bit mode splits it into two nibbles.
module lcd_seq_ctrl #(
    parameter int BUS4      = 0,
    parameter int TWO_LINE  = 1,
    parameter int CURSOR_ON = 1,
    parameter int BLINK_ON  = 0,
    parameter int PWR_WAIT  = 4000,
    parameter int CMD_WAIT  = 3,
    parameter int CLR_WAIT  = 152
) (
    input  logic       clk_1024,
    input  logic       reset_n,
    input  logic       reinit,
    input  logic       wr_req,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       ready,
    output logic       init_done,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);
    typedef enum logic [2:0] {PWR, INIT_SEND, INIT_HOLD, IDLE, WR_SEND, WR_HOLD} state_t;

    localparam bit          IS_BUS4   = (BUS4 != 0);
    localparam logic [15:0] PWR_TC    = 16'(PWR_WAIT);
    localparam logic [15:0] CMD_TC    = 16'(CMD_WAIT);
    localparam logic [15:0] CLR_TC    = 16'(CLR_WAIT);
    localparam logic [2:0]  ROM_FIRST = IS_BUS4 ? 3'd0 : 3'd1;
    localparam logic [2:0]  ROM_LAST  = 3'd4;
    localparam logic [7:0]  FUNC_SET  = 8'h20 | (IS_BUS4 ? 8'h00 : 8'h10) | ((TWO_LINE != 0) ? 8'h08 : 8'h00);
    localparam logic [7:0]  DISP_ON   = 8'h0C | ((CURSOR_ON != 0) ? 8'h02 : 8'h00) | ((BLINK_ON != 0) ? 8'h01 : 8'h00);

    // Entry 0 is the lone 0x2 nibble that switches the panel into 4-bit mode.
    function automatic logic [7:0] rom_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_byte = 8'h20;
            3'd1:    rom_byte = FUNC_SET;
            3'd2:    rom_byte = DISP_ON;
            3'd3:    rom_byte = 8'h01;
            default: rom_byte = 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] first_phase(input logic [7:0] b);
        first_phase = IS_BUS4 ? {b[7:4], 4'h0} : b;
    endfunction

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  byte_reg, byte_next;
    logic        rs_reg, rs_next;
    logic        nib_lo_reg, nib_lo_next;
    logic        single_reg, single_next;
    logic        e_reg, e_next;
    logic [7:0]  data_reg, data_next;
    logic        ready_reg, ready_next;
    logic        done_reg, done_next;
    logic [15:0] hold_w;
    logic        hi_pending;

    // A high nibble with its low half still to come only needs a one-cycle hold.
    assign hi_pending = IS_BUS4 && !nib_lo_reg && !single_reg;

    always_comb begin
        if (hi_pending)
            hold_w = 16'd1;
        else if (!rs_reg && (byte_reg == 8'h01 || byte_reg == 8'h02))
            hold_w = CLR_TC;
        else
            hold_w = CMD_TC;
    end

    always_ff @(posedge clk_1024 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= PWR;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            byte_reg   <= '0;
            rs_reg     <= 1'b0;
            nib_lo_reg <= 1'b0;
            single_reg <= 1'b0;
            e_reg      <= 1'b0;
            data_reg   <= '0;
            ready_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            byte_reg   <= byte_next;
            rs_reg     <= rs_next;
            nib_lo_reg <= nib_lo_next;
            single_reg <= single_next;
            e_reg      <= e_next;
            data_reg   <= data_next;
            ready_reg  <= ready_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        byte_next   = byte_reg;
        rs_next     = rs_reg;
        nib_lo_next = nib_lo_reg;
        single_next = single_reg;
        e_next      = 1'b0;
        data_next   = data_reg;
        ready_next  = ready_reg;
        done_next   = done_reg;
        case (state_reg)
            PWR: begin
                ready_next = 1'b0;
                if (cnt_reg == PWR_TC) begin
                    state_next  = INIT_SEND;
                    cnt_next    = '0;
                    idx_next    = ROM_FIRST;
                    byte_next   = rom_byte(ROM_FIRST);
                    rs_next     = 1'b0;
                    nib_lo_next = 1'b0;
                    single_next = IS_BUS4;
                    e_next      = 1'b1;
                    data_next   = first_phase(rom_byte(ROM_FIRST));
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            INIT_SEND, WR_SEND: begin
                state_next = (state_reg == INIT_SEND) ? INIT_HOLD : WR_HOLD;
                cnt_next   = 16'd1;
            end
            INIT_HOLD, WR_HOLD: begin
                if (cnt_reg != hold_w) begin
                    cnt_next = cnt_reg + 16'd1;
                end else if (hi_pending) begin
                    nib_lo_next = 1'b1;
                    e_next      = 1'b1;
                    data_next   = {byte_reg[3:0], 4'h0};
                    state_next  = (state_reg == INIT_HOLD) ? INIT_SEND : WR_SEND;
                end else if (state_reg == INIT_HOLD && idx_reg != ROM_LAST) begin
                    idx_next    = idx_reg + 3'd1;
                    byte_next   = rom_byte(idx_reg + 3'd1);
                    nib_lo_next = 1'b0;
                    single_next = 1'b0;
                    e_next      = 1'b1;
                    data_next   = first_phase(rom_byte(idx_reg + 3'd1));
                    state_next  = INIT_SEND;
                end else begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    done_next  = 1'b1;
                end
            end
            IDLE: begin
                if (wr_req) begin
                    byte_next   = wr_data;
                    rs_next     = wr_rs;
                    nib_lo_next = 1'b0;
                    single_next = 1'b0;
                    e_next      = 1'b1;
                    data_next   = first_phase(wr_data);
                    ready_next  = 1'b0;
                    state_next  = WR_SEND;
                end
            end
            default: state_next = PWR;
        endcase
        // Restart wins over everything, including a write accepted on the same edge.
        if (reinit) begin
            state_next  = PWR;
            cnt_next    = '0;
            e_next      = 1'b0;
            ready_next  = 1'b0;
            done_next   = 1'b0;
            nib_lo_next = 1'b0;
        end
    end

    assign ready     = ready_reg;
    assign init_done = done_reg;
    assign lcd_rw    = 1'b0;
    assign lcd_rs    = rs_reg;
    assign lcd_e     = e_reg;
    assign lcd_data  = data_reg;
endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Bench for lcd_seq_ctrl: default 8-bit instance for init/write/reinit/reset timing,
// plus a short-timed 4-bit instance for the nibble sequence.
module tb_lcd_seq_ctrl;
    localparam int B_PWR = 20;
    localparam int B_CMD = 3;
    localparam int B_CLR = 10;

    logic clk_1024 = 1'b0;
    always #5 clk_1024 = ~clk_1024;

    int cyc = 0;
    always @(posedge clk_1024) cyc <= cyc + 1;

    logic       reset_n, reinit, wr_req, wr_rs;
    logic [7:0] wr_data;
    logic       ready, init_done, lcd_rw, lcd_rs, lcd_e;
    logic [7:0] lcd_data;

    logic       reset_n_b, reinit_b, wr_req_b, wr_rs_b;
    logic [7:0] wr_data_b;
    logic       ready_b, init_done_b, lcd_rw_b, lcd_rs_b, lcd_e_b;
    logic [7:0] lcd_data_b;

    lcd_seq_ctrl dut (
        .clk_1024(clk_1024), .reset_n(reset_n), .reinit(reinit), .wr_req(wr_req),
        .wr_rs(wr_rs), .wr_data(wr_data), .ready(ready), .init_done(init_done),
        .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    lcd_seq_ctrl #(.BUS4(1), .PWR_WAIT(B_PWR), .CMD_WAIT(B_CMD), .CLR_WAIT(B_CLR)) dut_b (
        .clk_1024(clk_1024), .reset_n(reset_n_b), .reinit(reinit_b), .wr_req(wr_req_b),
        .wr_rs(wr_rs_b), .wr_data(wr_data_b), .ready(ready_b), .init_done(init_done_b),
        .lcd_rw(lcd_rw_b), .lcd_rs(lcd_rs_b), .lcd_e(lcd_e_b), .lcd_data(lcd_data_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         edge_n;
    } strobe_t;

    strobe_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int base = 0;
    int base_b = 0;

    function automatic strobe_t mk(input logic [7:0] d, input logic rs, input int e);
        strobe_t s;
        s.data = d;
        s.rs = rs;
        s.edge_n = e;
        return s;
    endfunction

    // Waits for the next E-high cycle on the 8-bit instance; flags any bus change while E is low.
    task automatic wait_strobe(input int limit, output logic [7:0] d, output logic rs,
                               output int at, output bit ok, output bit stable);
        logic [8:0] held;
        bit have;
        ok = 0; stable = 1; have = 0; d = '0; rs = 1'b0; at = 0; held = '0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_1024);
            if (lcd_e === 1'b1) begin
                d = lcd_data; rs = lcd_rs; at = cyc - base; ok = 1;
                break;
            end
            if (!have) begin
                held = {lcd_rs, lcd_data}; have = 1;
            end else if ({lcd_rs, lcd_data} !== held) begin
                stable = 0;
            end
        end
    endtask

    task automatic wait_strobe_b(input int limit, output logic [7:0] d, output logic rs,
                                 output int at, output bit ok);
        ok = 0; d = '0; rs = 1'b0; at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_1024);
            if (lcd_e_b === 1'b1) begin
                d = lcd_data_b; rs = lcd_rs_b; at = cyc - base_b; ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; reinit = 1'b0; wr_req = 1'b0; wr_rs = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk_1024);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b want=0", init_done); end
        checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL reset_lcd_e got=%b want=0", lcd_e); end
        checks++; if (lcd_rs !== 1'b0) begin failures++; $display("FAIL reset_lcd_rs got=%b want=0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0) begin failures++; $display("FAIL reset_lcd_rw got=%b want=0", lcd_rw); end
        checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL reset_lcd_data got=%02h want=00", lcd_data); end
        reset_n = 1'b1;
        base = cyc;
    endtask

    // Full 8-bit init sequence, timed from the edge recorded in base.
    task automatic test_init(input string nm);
        strobe_t s;
        logic [7:0] d;
        logic rs;
        int at, done_at;
        bit ok, stable;
        exp_q.push_back(mk(8'h38, 1'b0, 4001));
        exp_q.push_back(mk(8'h0E, 1'b0, 4005));
        exp_q.push_back(mk(8'h01, 1'b0, 4009));
        exp_q.push_back(mk(8'h06, 1'b0, 4162));
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            wait_strobe(5000, d, rs, at, ok, stable);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s_strobe_timeout got=none want=%02h@%0d", nm, s.data, s.edge_n);
                exp_q.delete();
                break;
            end
            $display("%s strobe data=%02h rs=%b edge=%0d", nm, d, rs, at);
            checks++; if (d !== s.data) begin failures++; $display("FAIL %s_data got=%02h want=%02h", nm, d, s.data); end
            checks++; if (rs !== s.rs) begin failures++; $display("FAIL %s_rs got=%b want=%b", nm, rs, s.rs); end
            checks++; if (at !== s.edge_n) begin failures++; $display("FAIL %s_edge got=%0d want=%0d", nm, at, s.edge_n); end
            checks++; if (stable !== 1'b1) begin failures++; $display("FAIL %s_hold_stable got=%b want=1", nm, stable); end
            checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL %s_done_early got=%b want=0", nm, init_done); end
        end
        done_at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_1024);
            if (init_done === 1'b1) begin
                done_at = cyc - base;
                break;
            end
        end
        $display("%s init_done edge=%0d", nm, done_at);
        checks++; if (done_at !== 4166) begin failures++; $display("FAIL %s_done_edge got=%0d want=4166", nm, done_at); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b want=1", nm, ready); end
    endtask

    // Data write, with a held request (and changed bus inputs) while busy.
    task automatic test_write_data();
        strobe_t s;
        int low, strobes;
        bit seen_ready;
        @(negedge clk_1024);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL wr_data_ready_pre got=%b want=1", ready); end
        wr_req = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
        base = cyc;
        exp_q.push_back(mk(8'h41, 1'b1, 1));
        low = 0; strobes = 0; seen_ready = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_1024);
            if (i == 0) begin wr_data = 8'h55; wr_rs = 1'b0; end
            if (lcd_e === 1'b1) begin
                strobes++;
                $display("wr_data strobe data=%02h rs=%b edge=%0d", lcd_data, lcd_rs, cyc - base);
                if (exp_q.size() > 0) begin
                    s = exp_q.pop_front();
                    checks++; if (lcd_data !== s.data) begin failures++; $display("FAIL wr_data_data got=%02h want=%02h", lcd_data, s.data); end
                    checks++; if (lcd_rs !== s.rs) begin failures++; $display("FAIL wr_data_rs got=%b want=%b", lcd_rs, s.rs); end
                    checks++; if (cyc - base !== s.edge_n) begin failures++; $display("FAIL wr_data_edge got=%0d want=%0d", cyc - base, s.edge_n); end
                end
            end
            if (!seen_ready) begin
                if (ready === 1'b1) begin
                    seen_ready = 1;
                    wr_req = 1'b0;
                    checks++; if (lcd_data !== 8'h41) begin failures++; $display("FAIL wr_data_held got=%02h want=41", lcd_data); end
                end else begin
                    low++;
                end
            end
        end
        wr_req = 1'b0;
        checks++; if (strobes !== 1) begin failures++; $display("FAIL wr_data_strobes got=%0d want=1", strobes); end
        checks++; if (low !== 4) begin failures++; $display("FAIL wr_data_busy got=%0d want=4", low); end
        exp_q.delete();
    endtask

    task automatic test_write_clear();
        int low, strobes, at;
        low = 0; strobes = 0; at = -1;
        @(negedge clk_1024);
        wr_req = 1'b1; wr_rs = 1'b0; wr_data = 8'h01;
        base = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_1024);
            wr_req = 1'b0;
            if (lcd_e === 1'b1) begin strobes++; at = cyc - base; end
            if (ready === 1'b1) break;
            low++;
        end
        $display("wr_clear strobes=%0d edge=%0d busy=%0d", strobes, at, low);
        checks++; if (strobes !== 1) begin failures++; $display("FAIL wr_clear_strobes got=%0d want=1", strobes); end
        checks++; if (at !== 1) begin failures++; $display("FAIL wr_clear_edge got=%0d want=1", at); end
        checks++; if (low !== 153) begin failures++; $display("FAIL wr_clear_busy got=%0d want=153", low); end
    endtask

    task automatic test_reinit_clear();
        @(negedge clk_1024);
        wr_req = 1'b1; wr_rs = 1'b0; wr_data = 8'h01;
        @(negedge clk_1024);
        wr_req = 1'b0;
        checks++; if (lcd_e !== 1'b1 || lcd_data !== 8'h01) begin failures++; $display("FAIL reinit_clr_strobe got=%b/%02h want=1/01", lcd_e, lcd_data); end
        repeat (50) @(negedge clk_1024);
        checks++; if (lcd_e !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL reinit_clr_hold got=%b/%b want=0/0", lcd_e, ready); end
        reinit = 1'b1;
        base = cyc + 1;
        @(negedge clk_1024);
        reinit = 1'b0;
        $display("reinit during clear hold init_done=%b ready=%b", init_done, ready);
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reinit_done got=%b want=0", init_done); end
        checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL reinit_lcd_e got=%b want=0", lcd_e); end
        test_init("reinit");
    endtask

    task automatic test_reinit_beats_wr();
        @(negedge clk_1024);
        reinit = 1'b1; wr_req = 1'b1; wr_rs = 1'b1; wr_data = 8'h77;
        base = cyc + 1;
        @(negedge clk_1024);
        reinit = 1'b0; wr_req = 1'b0;
        $display("reinit+wr lcd_e=%b ready=%b init_done=%b", lcd_e, ready, init_done);
        checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL reinit_wr_lcd_e got=%b want=0", lcd_e); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reinit_wr_ready got=%b want=0", ready); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reinit_wr_done got=%b want=0", init_done); end
    endtask

    // Reset asserted mid-strobe must drop E without waiting for a clock edge.
    task automatic test_async_reset();
        logic [7:0] d;
        logic rs;
        int at;
        bit ok, stable;
        wait_strobe(5000, d, rs, at, ok, stable);
        checks++; if (!ok || at !== 4001 || d !== 8'h38) begin failures++; $display("FAIL async_first_strobe got=%02h@%0d want=38@4001", d, at); end
        #2 reset_n = 1'b0;
        #1;
        $display("async reset lcd_e=%b lcd_data=%02h", lcd_e, lcd_data);
        checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL async_lcd_e got=%b want=0", lcd_e); end
        checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL async_lcd_data got=%02h want=00", lcd_data); end
        @(negedge clk_1024);
        reset_n = 1'b1;
        base = cyc;
        test_init("post_reset");
    endtask

    task automatic test_bus4();
        logic [3:0] nib [9];
        int w [9];
        strobe_t s;
        logic [7:0] d;
        logic rs;
        int at, e, done_at, low;
        bit ok;
        nib = '{4'h2, 4'h2, 4'h8, 4'h0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h6};
        w = '{B_CMD, 1, B_CMD, 1, B_CMD, 1, B_CLR, 1, B_CMD};
        reinit_b = 1'b0; wr_req_b = 1'b0; wr_rs_b = 1'b0; wr_data_b = '0;
        reset_n_b = 1'b0;
        repeat (2) @(negedge clk_1024);
        checks++; if (lcd_e_b !== 1'b0 || lcd_data_b !== 8'h00) begin failures++; $display("FAIL bus4_reset got=%b/%02h want=0/00", lcd_e_b, lcd_data_b); end
        e = B_PWR + 1;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(mk({nib[i], 4'h0}, 1'b0, e));
            e = e + 1 + w[i];
        end
        reset_n_b = 1'b1;
        base_b = cyc;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            wait_strobe_b(200, d, rs, at, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL bus4_timeout got=none want=%02h@%0d", s.data, s.edge_n);
                exp_q.delete();
                break;
            end
            $display("bus4 strobe data=%02h rs=%b edge=%0d", d, rs, at);
            checks++; if (d !== s.data) begin failures++; $display("FAIL bus4_data got=%02h want=%02h", d, s.data); end
            checks++; if (at !== s.edge_n) begin failures++; $display("FAIL bus4_edge got=%0d want=%0d", at, s.edge_n); end
        end
        done_at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_1024);
            if (init_done_b === 1'b1) begin done_at = cyc - base_b; break; end
        end
        checks++; if (done_at !== e) begin failures++; $display("FAIL bus4_done_edge got=%0d want=%0d", done_at, e); end
        // User write 0x41 as two nibbles: busy = 1+1 (high) + 1+CMD (low).
        exp_q.push_back(mk(8'h40, 1'b1, 1));
        exp_q.push_back(mk(8'h10, 1'b1, 3));
        @(negedge clk_1024);
        wr_req_b = 1'b1; wr_rs_b = 1'b1; wr_data_b = 8'h41;
        base_b = cyc;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_1024);
            wr_req_b = 1'b0;
            if (lcd_e_b === 1'b1) begin
                $display("bus4 wr strobe data=%02h rs=%b edge=%0d", lcd_data_b, lcd_rs_b, cyc - base_b);
                if (exp_q.size() > 0) begin
                    s = exp_q.pop_front();
                    checks++; if ({lcd_rs_b, lcd_data_b} !== {s.rs, s.data}) begin failures++; $display("FAIL bus4_wr_data got=%b/%02h want=%b/%02h", lcd_rs_b, lcd_data_b, s.rs, s.data); end
                    checks++; if (cyc - base_b !== s.edge_n) begin failures++; $display("FAIL bus4_wr_edge got=%0d want=%0d", cyc - base_b, s.edge_n); end
                end
            end
            if (ready_b === 1'b1) break;
            low++;
        end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL bus4_wr_missing got=%0d want=0", exp_q.size()); end
        checks++; if (low !== 2 + 1 + B_CMD) begin failures++; $display("FAIL bus4_wr_busy got=%0d want=%0d", low, 2 + 1 + B_CMD); end
        exp_q.delete();
    endtask

    initial begin
        reset_n_b = 1'b0; reinit_b = 1'b0; wr_req_b = 1'b0; wr_rs_b = 1'b0; wr_data_b = '0;
        test_reset();
        test_init("init");
        test_write_data();
        test_write_clear();
        test_reinit_clear();
        test_reinit_beats_wr();
        test_async_reset();
        test_bus4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
